// File: rtl/usr_ctrl_5bit.sv
// usr_ctrl_5bit: sequencer for an external universal shift register.
// Transmit: parallel-load a word, then shift it out one bit per cycle.
// Receive: shift WIDTH serial bits in, then capture the register into dout.
//
// Ports
//   clk       in   clock, rising-edge
//   rst       in   asynchronous active-low reset
//   start     in   request an operation (sampled in IDLE only)
//   op        in   0 = transmit, 1 = receive
//   dir       in   0 = shift right (LSB first), 1 = shift left (MSB first)
//   din       in   word to transmit
//   ser_in    in   serial receive data
//   abort     in   synchronous cancel of the current operation
//   po        in   parallel output of the controlled register
//   sel       out  register mode: 00 hold, 01 right, 10 left, 11 load
//   pi        out  parallel load word (latched din)
//   si        out  serial input to the register
//   ser_out   out  transmitted bit, valid while ser_valid is high
//   ser_valid out  high on each transmit shift cycle
//   dout      out  last received word
//   busy      out  high outside IDLE
//   done      out  one-cycle completion pulse
module usr_ctrl_5bit #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    input  logic             abort,
    input  logic [WIDTH-1:0] po,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] pi,
    output logic             si,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              op_q, op_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  pi_q, pi_d;
    logic [WIDTH-1:0]  dout_q, dout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            pi_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            pi_q    <= pi_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dir_d   = dir_q;
        pi_d    = pi_q;
        dout_d  = dout_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    op_d    = op;
                    dir_d   = dir;
                    pi_d    = din;
                    cnt_d   = '0;
                    state_d = op ? StShift : StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                // Counter ends at WIDTH after the last shift edge, never beyond.
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = op_q ? StCapture : StDone;
                end
            end
            StCapture: begin
                dout_d  = po;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over everything outside IDLE; a pending capture is dropped.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            dout_d  = dout_q;
        end
    end

    // Moore outputs (si follows ser_in combinationally while receiving)
    always_comb begin
        sel       = 2'b00;
        si        = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StLoad: begin
                sel = 2'b11;
            end
            StShift: begin
                sel = dir_q ? 2'b10 : 2'b01;
                if (op_q) begin
                    si = ser_in;
                end else begin
                    ser_valid = 1'b1;
                    ser_out   = dir_q ? po[WIDTH-1] : po[0];
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pi   = pi_q;
    assign dout = dout_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_usr_ctrl_5bit.sv
module tb_usr_ctrl_5bit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, op, dir, ser_in, abort;
    logic [W-1:0] din;
    logic [W-1:0] po;
    logic [1:0]   sel;
    logic [W-1:0] pi;
    logic         si, ser_out, ser_valid, busy, done;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_dout;

    usr_ctrl_5bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dir       (dir),
        .din       (din),
        .ser_in    (ser_in),
        .abort     (abort),
        .po        (po),
        .sel       (sel),
        .pi        (pi),
        .si        (si),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // The controlled universal shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            po <= '0;
        end else begin
            case (sel)
                2'b01:   po <= {si, po[W-1:1]};
                2'b10:   po <= {po[W-2:0], si};
                2'b11:   po <= pi;
                default: po <= po;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed control view: {sel, si, ser_out, ser_valid, busy, done}
    function automatic logic [6:0] ctl_vec();
        return {sel, si, ser_out, ser_valid, busy, done};
    endfunction

    // One full operation. abort_at = 0: none; otherwise abort is raised in
    // that cycle (1 = first cycle after the start edge). Start is toggled
    // randomly while busy to confirm it is ignored.
    task automatic run_op(input logic o, input logic d, input logic [W-1:0] word,
                          input logic [W-1:0] bits, input int abort_at);
        logic [6:0] exp_ctl;
        logic [W-1:0] rx_word;
        int k;
        start = 1'b1; op = o; dir = d; din = word; abort = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= W + 2; c++) begin
            start  = 1'($urandom_range(0, 1));
            op     = 1'($urandom_range(0, 1));
            din    = W'($urandom);
            abort  = (c == abort_at);
            k      = o ? c - 1 : c - 2;
            ser_in = (o && k >= 0 && k < W) ? bits[k] : 1'($urandom_range(0, 1));
            #1;
            // Expected outputs from the operation's cycle plan
            exp_ctl = 7'b0000_010;
            if (!o && c == 1) begin
                exp_ctl[6:5] = 2'b11;
            end else if (k >= 0 && k < W) begin
                exp_ctl[6:5] = d ? 2'b10 : 2'b01;
                if (o) begin
                    exp_ctl[4] = bits[k];
                end else begin
                    exp_ctl[3] = d ? word[W-1-k] : word[k];
                    exp_ctl[2] = 1'b1;
                end
            end else if (c == W + 2) begin
                exp_ctl[0] = 1'b1;
            end
            check_eq($sformatf("ctl op%0d dir%0d c%0d", o, d, c), 32'(ctl_vec()), 32'(exp_ctl));
            check_eq("pi", 32'(pi), 32'(word));
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                abort = 1'b0;
                start = 1'b0;
                #1;
                check_eq("abort busy", 32'(busy), 32'd0);
                check_eq("abort done", 32'(done), 32'd0);
                check_eq("abort dout", 32'(dout), 32'(exp_dout));
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (o) begin
            for (int i = 0; i < W; i++) begin
                rx_word[d ? W - 1 - i : i] = bits[i];
            end
            exp_dout = rx_word;
        end
        #1;
        check_eq("end busy", 32'(busy), 32'd0);
        check_eq("end dout", 32'(dout), 32'(exp_dout));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 1'b0; dir = 1'b0; din = '0;
        ser_in = 1'b0; abort = 1'b0;
        exp_dout = '0;
        #2;
        check_eq("reset ctl", 32'(ctl_vec()), 32'd0);
        check_eq("reset pi", 32'(pi), 32'd0);
        check_eq("reset dout", 32'(dout), 32'd0);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(1'b0, 1'b0, 5'b10110, 5'b0, 0);
        run_op(1'b0, 1'b1, 5'b10110, 5'b0, 0);
        run_op(1'b1, 1'b0, 5'b0, 5'b11001, 0);   // bits 1,0,0,1,1 in time order
        check_eq("rx right word", 32'(dout), 32'h19);
        run_op(1'b0, 1'b0, 5'b01111, 5'b0, 4);   // abort in third SHIFT cycle
        run_op(1'b1, 1'b1, 5'b0, 5'b10101, 6);   // abort in CAPTURE

        // start with abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        #1;
        check_eq("start+abort idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a transmit
        start = 1'b1; op = 1'b0; dir = 1'b0; din = 5'b11011;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        exp_dout = '0;
        check_eq("mid reset ctl", 32'(ctl_vec()), 32'd0);
        check_eq("mid reset pi", 32'(pi), 32'd0);
        check_eq("mid reset dout", 32'(dout), 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b0, 1'b0, 5'b01010, 5'b0, 0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
                   W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 2)) : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
